// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Accepts fetch addresses from the PC
//                register, keeps a single read outstanding on the instruction
//                memory req/ack port and queues {pc, instr, fault} entries for
//                decode over a valid/ready interface. A flush empties the
//                queue and discards any read still in flight.
//                Optional build macro FETCH_ALIGN_CHECK_EN: misaligned fetch
//                addresses issue no memory read and instead queue a fault
//                entry at the accept edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    input  logic        instr_ready
);

    localparam int                  c_ptr_w   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                  c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]  c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0]  c_ptr_one = c_ptr_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 imem_req_q, imem_req_d;
    logic [31:0]          imem_addr_q, imem_addr_d;
    logic [31:0]          tag_q, tag_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic [31:0]          mem_instr_q [DEPTH];
    logic [31:0]          mem_instr_d [DEPTH];
    logic [31:0]          mem_pc_q    [DEPTH];
    logic [31:0]          mem_pc_d    [DEPTH];
`ifdef FETCH_ALIGN_CHECK_EN
    logic                 mem_fault_q [DEPTH];
    logic                 mem_fault_d [DEPTH];
    logic                 w_misaligned;
`endif

    logic                 w_accept;
    logic                 w_issue;
    logic                 w_ack_push;
    logic                 w_push;
    logic                 w_pop;
    logic [31:0]          w_push_instr;
    logic [31:0]          w_push_pc;

    // Space is reserved at accept time, so a returning read always has a slot.
    assign pc_ready    = (state_q == ST_IDLE) && (count_q < c_depth) && !flush;
    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = (count_q != '0);
    assign instr       = mem_instr_q[rd_ptr_q];
    assign instr_pc    = mem_pc_q[rd_ptr_q];
`ifdef FETCH_ALIGN_CHECK_EN
    assign instr_fault = mem_fault_q[rd_ptr_q];
`else
    assign instr_fault = 1'b0;
`endif

    // Handshake decode and selection of the entry to push this cycle.
    always_comb begin
        w_accept   = pc_valid && pc_ready;
        w_ack_push = (state_q == ST_WAIT) && imem_ack && !flush;
        w_pop      = instr_valid && instr_ready;
`ifdef FETCH_ALIGN_CHECK_EN
        w_misaligned = w_accept && (pc_in[1:0] != 2'b00);
        w_issue      = w_accept && !w_misaligned;
        w_push       = w_ack_push || w_misaligned;
        w_push_pc    = w_ack_push ? tag_q : pc_in;
        w_push_instr = w_ack_push ? imem_rdata : 32'h0000_0000;
`else
        w_issue      = w_accept;
        w_push       = w_ack_push;
        w_push_pc    = tag_q;
        w_push_instr = imem_rdata;
`endif
    end

    // Request FSM: one read in flight; a flush while waiting turns the
    // pending read into a discard until its ack arrives.
    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        tag_d       = tag_q;
        case (state_q)
            ST_IDLE: begin
                if (w_issue) begin
                    state_d     = ST_WAIT;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_in;
                    tag_d       = pc_in;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    state_d    = ST_IDLE;
                    imem_req_d = 1'b0;
                end else if (flush) begin
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    state_d    = ST_IDLE;
                    imem_req_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // Queue pointer/occupancy update; flush empties the queue on its edge.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_ptr_one;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_cnt_one;
                2'b01:   count_d = count_q - c_cnt_one;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue storage: write the pushed entry at the tail slot.
    always_comb begin
        mem_instr_d = mem_instr_q;
        mem_pc_d    = mem_pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
        mem_fault_d = mem_fault_q;
`endif
        if (w_push) begin
            mem_instr_d[wr_ptr_q] = w_push_instr;
            mem_pc_d[wr_ptr_q]    = w_push_pc;
`ifdef FETCH_ALIGN_CHECK_EN
            mem_fault_d[wr_ptr_q] = w_misaligned;
`endif
        end
    end

    // All state registers; reset abandons any outstanding read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= 32'h0000_0000;
            tag_q       <= 32'h0000_0000;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= 32'h0000_0000;
                mem_pc_q[i]    <= 32'h0000_0000;
`ifdef FETCH_ALIGN_CHECK_EN
                mem_fault_q[i] <= 1'b0;
`endif
            end
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            tag_q       <= tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_instr_q <= mem_instr_d;
            mem_pc_q    <= mem_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
            mem_fault_q <= mem_fault_d;
`endif
        end
    end

endmodule
`default_nettype wire
